// File: rtl/adder_pipe_pkg.sv
// adder_pkg: shared types and helpers for the pipelined adder/subtractor.
// Provides the op encoding and the per-stage slice width calculation.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Bits handled by each registered stage.
    function automatic int slice_width(input int bit_width, input int stages);
        return bit_width / stages;
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operand/result bundle with valid/ready on both sides.
// master = operand source and result consumer; slave = the adder pipeline.
//   in_valid/in_ready, a, b, carry_in, op      : operand beat
//   out_valid/out_ready, sum, carry_out, overflow : result beat
interface adder_pipe_if #(
    parameter int BIT_WIDTH = 8
);
    import adder_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic                 carry_in;
    op_e                  op;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] sum;
    logic                 carry_out;
    logic                 overflow;

    modport master (
        output in_valid,
        output a,
        output b,
        output carry_in,
        output op,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  carry_out,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  carry_in,
        input  op,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output carry_out,
        output overflow
    );

endinterface

// File: rtl/adder_pipe_slice.sv
// adder_slice: one registered W-bit slice of the pipelined carry chain.
// Ports: clk, rst (async high); en = pipeline advance; vin/vout = beat valid;
//   a, b, cin = slice operands and carry in; s, cout = registered slice result;
//   a_msb, b_msb = registered operand MSBs for the signed-overflow check.
module adder_slice
    import adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         vin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         vout,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         a_msb,
    output logic         b_msb
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

    // Bubbles only move the valid bit; data registers keep their contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vout  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (en) begin
            vout <= vin;
            if (vin) begin
                s     <= total[W-1:0];
                cout  <= total[W];
                a_msb <= a[W-1];
                b_msb <= b[W-1];
            end
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: STAGES-deep pipelined BIT_WIDTH adder/subtractor with valid/ready.
// Ports: clk, rst (async high), bus (adder_pipe_if.slave operand/result beats).
// Optional: define ADDER_PIPE_SATURATE_EN for unsigned saturation of sum.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int STAGES    = 2
) (
    input logic         clk,
    input logic         rst,
    adder_pipe_if.slave bus
);

    localparam int W = slice_width(BIT_WIDTH, STAGES);
    localparam int L = STAGES - 1;

    logic                 adv;
    logic [BIT_WIDTH-1:0] b_eff;
    logic                 c0;

    // Per-stage inputs (combinational) and skew/deskew registers.
    logic [STAGES-1:0][BIT_WIDTH-1:0] a_in;
    logic [STAGES-1:0][BIT_WIDTH-1:0] b_in;
    logic [STAGES-1:0][BIT_WIDTH-1:0] lo_in;
    logic [STAGES-1:0][BIT_WIDTH-1:0] a_q;
    logic [STAGES-1:0][BIT_WIDTH-1:0] b_q;
    logic [STAGES-1:0][BIT_WIDTH-1:0] lo_q;
    logic [STAGES-1:0]                vin;
    logic [STAGES-1:0]                cin_s;

    // Slice outputs.
    logic [STAGES-1:0]        vout;
    logic [STAGES-1:0][W-1:0] s;
    logic [STAGES-1:0]        co;
    logic [STAGES-1:0]        am;
    logic [STAGES-1:0]        bm;

    logic [BIT_WIDTH-1:0] sum_raw;
    logic [BIT_WIDTH-1:0] sum_out;

    // Whole pipeline moves in lockstep; bubbles are never squeezed out.
    assign adv          = bus.out_ready | ~vout[L];
    assign bus.in_ready = adv;

    // Subtraction is a + ~b + 1, so the inverted operand enters stage 0.
    assign b_eff = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    assign c0    = (bus.op == OP_SUB) ? 1'b1 : bus.carry_in;

    always_comb begin
        a_in     = '0;
        b_in     = '0;
        lo_in    = '0;
        vin      = '0;
        cin_s    = '0;
        a_in[0]  = bus.a;
        b_in[0]  = b_eff;
        vin[0]   = bus.in_valid;
        cin_s[0] = c0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]  = a_q[k-1];
            b_in[k]  = b_q[k-1];
            vin[k]   = vout[k-1];
            cin_s[k] = co[k-1];
            // Collect finished low slices so the beat exits as one word.
            lo_in[k] = lo_q[k-1];
            lo_in[k][(k-1)*W +: W] = s[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            lo_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv && vin[k]) begin
                    a_q[k]  <= a_in[k];
                    b_q[k]  <= b_in[k];
                    lo_q[k] <= lo_in[k];
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_slice #(
            .W(W)
        ) u_slice (
            .clk  (clk),
            .rst  (rst),
            .en   (adv),
            .vin  (vin[k]),
            .a    (a_in[k][k*W +: W]),
            .b    (b_in[k][k*W +: W]),
            .cin  (cin_s[k]),
            .vout (vout[k]),
            .s    (s[k]),
            .cout (co[k]),
            .a_msb(am[k]),
            .b_msb(bm[k])
        );
    end

    always_comb begin
        sum_raw = lo_q[L];
        sum_raw[L*W +: W] = s[L];
    end

`ifdef ADDER_PIPE_SATURATE_EN
    // Op travels with the beat so the last stage knows which way to clamp.
    logic [STAGES-1:0] sub_in;
    logic [STAGES-1:0] sub_q;

    always_comb begin
        sub_in    = '0;
        sub_in[0] = (bus.op == OP_SUB);
        for (int k = 1; k < STAGES; k++) begin
            sub_in[k] = sub_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv && vin[k]) begin
                    sub_q[k] <= sub_in[k];
                end
            end
        end
    end

    always_comb begin
        sum_out = sum_raw;
        if (!sub_q[L] && co[L]) begin
            sum_out = '1;
        end else if (sub_q[L] && !co[L]) begin
            sum_out = '0;
        end
    end
`else
    assign sum_out = sum_raw;
`endif

    assign bus.out_valid = vout[L];
    assign bus.sum       = sum_out;
    assign bus.carry_out = co[L];
    // Overflow judged on the unsaturated sum and the effective B operand.
    assign bus.overflow  = (am[L] == bm[L]) && (sum_raw[BIT_WIDTH-1] != am[L]);

    // Skew/deskew bits outside each stage's live window are intentionally dead.
    logic unused_bits;
    assign unused_bits = ^{a_q, b_q, lo_q, a_in, b_in, am, bm};

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Pipelined, parametrised N-bit adder/subtractor; successor to the single-register clocked adder in the arithmetic datapath.
- The carry chain is split into STAGES registered slices so wide operands close timing.
- Adds an add/subtract mode, signed-overflow flag and valid/ready flow control with backpressure.
- Sits between operand sources and consumers, such as accumulators and comparators, that may stall.

Parameters:
BIT_WIDTH, 8, operand/result width; must be a multiple of STAGES.
STAGES, 2, register stages = latency in cycles; legal 1..BIT_WIDTH. Each stage computes BIT_WIDTH/STAGES bits.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  operand beat present.
in_ready  output  1  pipeline accepts a beat this cycle.
a  input  BIT_WIDTH  operand A, unsigned or two's complement.
b  input  BIT_WIDTH  operand B.
carry_in  input  1  carry into bit 0; add mode only.
op  input  1  adder_pkg::op_e: OP_ADD=0, OP_SUB=1.
out_valid  output  1  result beat present.
out_ready  input  1  consumer accepts the result.
sum  output  BIT_WIDTH  result.
carry_out  output  1  carry out of the MSB; in sub mode 1 means no borrow.
overflow  output  1  signed overflow.

Behaviour:
- Reset (async assert, sync release at clk edge): all stage valid bits 0; out_valid=0; sum=0; carry_out=0; overflow=0. in_ready is 1 in reset since the pipeline is empty.
- Global advance: adv = out_ready | ~out_valid. in_ready = adv. All stages shift only when adv=1.
- Beat accepted when in_valid & in_ready.
- Bubbles shift through the pipeline. They are not collapsed.
- Latency: an accepted beat appears on out_valid/sum exactly STAGES cycles later, provided adv was 1 on every intervening cycle. Each cycle with adv=0 adds one cycle.
- Throughput: 1 beat/cycle when out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, sum/carry_out/overflow/out_valid hold constant.
- Arithmetic, add mode: {carry_out,sum} = a + b + carry_in, with (BIT_WIDTH+1)-bit result.
- Arithmetic, sub mode: {carry_out,sum} = a + ~b + 1. carry_in is ignored.
- overflow = (a_msb == b'_msb) & (sum_msb != a_msb), where b' is the effective B operand (b or ~b).
- Slicing: stage k adds bits [k*W +: W], with W = BIT_WIDTH/STAGES, using the carry registered from stage k-1.
  - Operand upper slices are delay-registered (skewed) to stay aligned.
  - Lower result slices are delay-registered (deskewed) so all bits of a beat exit together.
- Bubble stages keep their data registers unchanged. Only valid bits are meaningful.
- Mid-operation reset: all in-flight beats are discarded. The first post-reset output comes from the first beat accepted after release.
- STAGES=1: behaves as a single registered adder with handshake; latency 1.
- Simultaneous accept and output drain in one cycle is legal and required for full throughput.

Optional Feature:
- Macro: ADDER_PIPE_SATURATE_EN.
- When defined, final-stage unsigned saturation applies:
  - Add mode with carry_out=1: sum forced to all ones.
  - Sub mode with carry_out=0 (borrow): sum forced to 0.
  - carry_out and overflow are still reported unmodified.
- When undefined: sum wraps modulo 2^BIT_WIDTH and there is no saturation logic.

Decomposition:
- Package adder_pkg holds:
  - typedef enum logic {OP_ADD, OP_SUB} op_e;
  - function slice_width(BIT_WIDTH, STAGES).
- Sub-module adder_slice, one registered stage: inputs are slice operands, carry and valid/enable; outputs are the slice sum, carry, and MSB operand bits for the overflow calculation.
- adder_pipe generates STAGES instances plus the skew and deskew registers.

Test Plan:
- BIT_WIDTH=8, STAGES=2, out_ready=1; add a=0x7F, b=0x01, cin=0 -> 2 cycles later sum=0x80, carry_out=0, overflow=1.
- Sub a=0x05, b=0x07 -> sum=0xFE, carry_out=0, overflow=0. With ADDER_PIPE_SATURATE_EN: sum=0x00.
- Add a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry_out=1, overflow=0. With ADDER_PIPE_SATURATE_EN: sum=0xFF.
- Back-to-back stream of 16 random beats with out_ready toggling 1010…:
  - Every beat matches the golden model, in order, with none lost or duplicated.
  - Outputs are stable while stalled.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0, sum=0 immediately (async). The next accepted beat emerges after exactly STAGES cycles.
- Sweep STAGES=1, 2, 4, 8 at BIT_WIDTH=8 with exhaustive a/b for add and sub -> all results and flags match the model; latency equals STAGES.
